// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Round-robin arbiter and select sequencer for a shared N-input,
//            W-bit mux. Accepts one requester per cycle into a single-entry
//            registered output stage with valid/ready handshakes.
//            Optional macro MUX_ARB_LOCK_EN adds a per-requester lock input
//            that holds the round-robin pointer on the locked winner.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       muxin,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]         lock,
`endif
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int SELW = $clog2(N);
  // One extra bit so ptr + offset never overflows before the modulo-N fold.
  localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N-1);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] winner;
  logic            found;
  logic [SELW:0]   cand;
  logic            can_load;
  logic            take;
  logic [SELW-1:0] ptr_adv;
  logic [W-1:0]    slot [N];

  // Unflatten the choice bus so the winner can index it directly.
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign slot[i] = muxin[i*W +: W];
  end

  assign can_load = !out_valid || out_ready;
  assign busy     = out_valid;

  // Search ptr, ptr+1, ..., wrapping at N, for the first active request.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (SELW+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && req[cand[SELW-1:0]]) begin
        found  = 1'b1;
        winner = cand[SELW-1:0];
      end
    end
  end

  // One-hot grant; suppressed while in reset or while the output stage stalls.
  always_comb begin
    gnt = '0;
    if (rst_n && can_load && found) gnt[winner] = 1'b1;
  end

  assign take    = |gnt;
  assign ptr_adv = (winner == LAST) ? '0 : winner + 1'b1;

  // Output stage and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= slot[winner];
      sel       <= winner;
`ifdef MUX_ARB_LOCK_EN
      ptr       <= lock[winner] ? winner : ptr_adv;
`else
      ptr       <= ptr_adv;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
